sd_to_binary_converter: RTL and testbench

Digit-serial on-the-fly converter (OTFC) that turns one redundant radix-4 signed-digit vector from the multiply-add stage into a two's-complement binary word. It sits directly downstream of the registered multiply-add output. It captures a full digit vector through a valid/ready handshake, consumes one digit per cycle MSD-first with no carry-propagate adder, and holds the binary result until the consumer takes it.

---
 rtl/sd_pkg.sv | 6 +
 rtl/sd_to_binary_converter_otfc_step.sv | 30 +++
 rtl/sd_to_binary_converter.sv | 66 ++++++
 tb/tb_sd_to_binary_converter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// sd_pkg: shared digit type, illegal code and FSM states for the signed-digit converter
package sd_pkg;
  typedef logic signed [2:0] sd_digit_t;
  localparam sd_digit_t SD_ILLEGAL = 3'b100;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
endpackage

// File: rtl/sd_to_binary_converter_otfc_step.sv
// otfc_step: one on-the-fly conversion step; appends digit d to Q (value) and QM (value-1)
//   q, qm   : current Q and QM words
//   d       : radix-4 digit, -4 is treated as 0 and flagged on illegal
//   q_nxt   : 4*Q + d
//   qm_nxt  : 4*Q + d - 1
module otfc_step
  import sd_pkg::*;
#(
  parameter int OUT_W = 33
) (
  input  logic [OUT_W-1:0] q,
  input  logic [OUT_W-1:0] qm,
  input  sd_digit_t        d,
  output logic [OUT_W-1:0] q_nxt,
  output logic [OUT_W-1:0] qm_nxt,
  output logic             illegal
);
  sd_digit_t dd;
  logic pos;
  logic [1:0] lo;
  always_comb begin
    illegal = d == SD_ILLEGAL;
    dd = illegal ? '0 : d;
    pos = !dd[2] && dd != '0;
    // (4+d) mod 4 is just d[1:0]; both d-1 and 3+d reduce to d[1:0]-1 mod 4
    lo = dd[1:0] - 2'd1;
    q_nxt = dd[2] ? {qm[OUT_W-3:0], dd[1:0]} : {q[OUT_W-3:0], dd[1:0]};
    qm_nxt = pos ? {q[OUT_W-3:0], lo} : {qm[OUT_W-3:0], lo};
  end
endmodule

// File: rtl/sd_to_binary_converter.sv
// sd_to_binary_converter: digit-serial MSD-first radix-4 signed-digit to two's-complement converter
//   in_valid/in_ready/in_digits   : vector handshake, in_digits[WIDTH-1] is the MSD
//   out_valid/out_ready/out_data  : result handshake, result held until consumed
//   out_err                       : an illegal digit (-4) occurred in the vector
module sd_to_binary_converter
  import sd_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int OUT_W = 2*WIDTH+1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0][2:0] in_digits,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_err
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  state_t state;
  logic [WIDTH-1:0][2:0] sr;
  logic [OUT_W-1:0] q, qm, q_nxt, qm_nxt;
  logic [CW-1:0] cnt;
  logic err, illegal, accept;
  otfc_step #(.OUT_W(OUT_W)) u_step (
    .q      (q),
    .qm     (qm),
    .d      (sr[WIDTH-1]),
    .q_nxt  (q_nxt),
    .qm_nxt (qm_nxt),
    .illegal(illegal)
  );
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign out_valid = state == DONE;
  assign out_data = q;
  assign out_err = err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      q <= '0;
      qm <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else if (accept) begin
      state <= CONV;
      sr <= in_digits;
      q <= '0;
      qm <= '1;
      cnt <= CW'(WIDTH-1);
      err <= 1'b0;
    end else if (state == CONV) begin
      sr <= {sr[WIDTH-2:0], 3'b000};
      q <= q_nxt;
      qm <= qm_nxt;
      err <= err || illegal;
      cnt <= cnt - 1'b1;
      state <= cnt == '0 ? DONE : CONV;
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_sd_to_binary_converter.sv
// tb_sd_to_binary_converter: randomized and directed check of the converter against a sum-of-digits model
module tb_sd_to_binary_converter;
  localparam int W = 4;
  typedef logic [W-1:0][2:0] vec_t;
  typedef struct {logic [8:0] d; logic e; int t0;} exp_t;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, out_ready = 1, out_err;
  vec_t in_digits = '0;
  logic [8:0] out_data;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  exp_t sb[$];
  int rise_c[$];
  logic [8:0] rise_d[$];
  bit rnd;

  sd_to_binary_converter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_digits(in_digits),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic vec_t mk(int a, int b, int c, int d);
    vec_t v;
    v[3] = a[2:0];
    v[2] = b[2:0];
    v[1] = c[2:0];
    v[0] = d[2:0];
    return v;
  endfunction

  function automatic logic [8:0] mdl(vec_t v);
    int s = 0;
    for (int i = 0; i < W; i++)
      if (v[i] != 3'b100) s += int'($signed(v[i])) * (4 ** i);
    return s[8:0];
  endfunction

  function automatic logic mdl_err(vec_t v);
    for (int i = 0; i < W; i++) if (v[i] == 3'b100) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      check("rst_valid", 32'(out_valid), 0);
      check("rst_ready", 32'(in_ready), 1);
    end else begin
      automatic bit ev = sb.size() > 0 && cyc >= sb[0].t0 + W;
      check("out_valid", 32'(out_valid), 32'(ev));
      check("in_ready", 32'(in_ready), 32'(sb.size() == 0 || (ev && out_ready)));
      if (ev && out_valid) begin
        check("out_data", 32'(out_data), 32'(sb[0].d));
        check("out_err", 32'(out_err), 32'(sb[0].e));
        if (cyc == sb[0].t0 + W) begin
          rise_c.push_back(cyc);
          rise_d.push_back(out_data);
        end
      end
      if (ev && out_ready) void'(sb.pop_front());
      if (in_valid && in_ready) sb.push_back('{mdl(in_digits), mdl_err(in_digits), cyc + 1});
    end
  end

  task automatic send(input vec_t v, output int waited);
    in_valid = 1;
    in_digits = v;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    in_digits = vec_t'($urandom);
  endtask

  task automatic wait_out(input string nm, input logic [8:0] ed, input logic ee);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check({nm, "_timeout"}, 0, 1);
    else begin
      check({nm, "_data"}, 32'(out_data), 32'(ed));
      check({nm, "_err"}, 32'(out_err), 32'(ee));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    check("pin_mdl_64", 32'(mdl(mk(1, 0, 0, 0))), 64);
    check("pin_mdl_23", 32'(mdl(mk(1, -3, 2, -1))), 23);
    check("pin_mdl_m255", 32'(mdl(mk(-3, -3, -3, -3))), 9'h101);
    check("pin_mdl_ill", 32'(mdl(mk(0, 4, 1, 0))), 4);
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check("reset_data", 32'(out_data), 0);
    check("reset_err", 32'(out_err), 0);
    check("reset_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    send(mk(1, 0, 0, 0), w);
    wait_out("pos_msd", 9'd64, 0);
    send(mk(1, -3, 2, -1), w);
    wait_out("mixed", 9'd23, 0);
    send(mk(-1, 0, 0, 0), w);
    wait_out("neg_msd", 9'h1C0, 0);
    send(mk(3, 3, 3, 3), w);
    wait_out("max", 9'd255, 0);
    send(mk(-3, -3, -3, -3), w);
    wait_out("min", 9'h101, 0);
    send(mk(0, 4, 1, 0), w);
    wait_out("illegal", 9'd4, 1);
    send(mk(0, 0, 2, 0), w);
    wait_out("after_illegal", 9'd8, 0);
    out_ready = 0;
    send(mk(1, -3, 2, -1), w);
    wait_out("bp", 9'd23, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 1);
      check("bp_data", 32'(out_data), 23);
      check("bp_ready", 32'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    send(mk(-1, 0, 0, 0), w);
    check("bp_same_cycle", 32'(w), 0);
    wait_out("bp_next", 9'h1C0, 0);
    rise_c.delete();
    rise_d.delete();
    send(mk(1, 0, 0, 0), w);
    send(mk(2, 0, 0, 0), w);
    w = 0;
    while (rise_c.size() < 2 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (rise_c.size() < 2) check("b2b_timeout", 0, 1);
    else begin
      check("b2b_first", 32'(rise_d[0]), 64);
      check("b2b_second", 32'(rise_d[1]), 128);
      check("b2b_spacing", 32'(rise_c[1] - rise_c[0]), 5);
    end
    @(posedge clk);
    #1;
    send(mk(3, -2, 1, 3), w);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1;
    @(negedge clk);
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_ready", 32'(in_ready), 1);
    check("midrst_data", 32'(out_data), 0);
    @(posedge clk);
    #1;
    rst = 0;
    send(mk(0, 0, 0, 1), w);
    wait_out("after_rst", 9'd1, 0);
    rnd = 1;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          send(vec_t'($urandom), w);
        end
        rnd = 0;
      end
      begin
        while (rnd) begin
          @(posedge clk);
          #1;
          if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1;
    w = 0;
    while (sb.size() > 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("drain", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
